// File: rtl/glb_strm_mux_pipe.sv
// Stream mux between a GLB tile's DMA ports and NUM_CHAN CGRA columns, with
// configurable pipelining, drained config updates and stretched soft reset.
module glb_strm_mux_pipe #(
  parameter int unsigned NUM_CHAN    = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned G2F_PIPE    = 1,
  parameter int unsigned F2G_PIPE    = 1,
  parameter int unsigned SRST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] g2f_dma_data,
  input  logic                  g2f_dma_valid,
  output logic [DATA_WIDTH-1:0] g2f_data [NUM_CHAN],
  output logic [NUM_CHAN-1:0]   g2f_valid,
  input  logic [DATA_WIDTH-1:0] f2g_data [NUM_CHAN],
  input  logic [NUM_CHAN-1:0]   f2g_valid,
  output logic [DATA_WIDTH-1:0] f2g_dma_data,
  output logic                  f2g_dma_valid,
  input  logic                  cgra_soft_reset,
  input  logic [NUM_CHAN-1:0]   cfg_g2f_mux,
  input  logic [NUM_CHAN-1:0]   cfg_f2g_mux,
  input  logic [NUM_CHAN-1:0]   cfg_soft_reset_mux,
  input  logic                  cfg_update,
  output logic                  cfg_busy,
  output logic                  cfg_err
);

  localparam int unsigned DRAIN_CYCLES = (G2F_PIPE > F2G_PIPE) ? G2F_PIPE : F2G_PIPE;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_e;

  state_e              state_q, state_d;
  logic [2:0]          drain_cnt_q, drain_cnt_d;
  logic [NUM_CHAN-1:0] act_g2f_q, act_g2f_d, act_f2g_q, act_f2g_d, act_srst_q, act_srst_d;
  logic [NUM_CHAN-1:0] shd_g2f_q, shd_g2f_d, shd_f2g_q, shd_f2g_d, shd_srst_q, shd_srst_d;
  logic                cfg_err_q, cfg_err_d;
  logic                cfg_busy_q, cfg_busy_d;
  logic [3:0]          srst_cnt_q, srst_cnt_d;
  logic                srst_s_q, srst_s_d;

  logic [DATA_WIDTH-1:0] g2f_s0_data [NUM_CHAN];
  logic [NUM_CHAN-1:0]   g2f_s0_valid;
  logic [DATA_WIDTH-1:0] g2f_pipe_data_q [G2F_PIPE][NUM_CHAN];
  logic [DATA_WIDTH-1:0] g2f_pipe_data_d [G2F_PIPE][NUM_CHAN];
  logic [NUM_CHAN-1:0]   g2f_pipe_valid_q [G2F_PIPE];
  logic [NUM_CHAN-1:0]   g2f_pipe_valid_d [G2F_PIPE];

  logic [DATA_WIDTH-1:0] f2g_s0_data;
  logic                  f2g_s0_valid;
  logic                  f2g_found;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    act_g2f_d   = act_g2f_q;
    act_f2g_d   = act_f2g_q;
    act_srst_d  = act_srst_q;
    shd_g2f_d   = shd_g2f_q;
    shd_f2g_d   = shd_f2g_q;
    shd_srst_d  = shd_srst_q;
    cfg_err_d   = cfg_err_q;
    unique case (state_q)
      ST_RUN: begin
        if (cfg_update) begin
          shd_g2f_d   = cfg_g2f_mux;
          shd_f2g_d   = cfg_f2g_mux;
          shd_srst_d  = cfg_soft_reset_mux;
          drain_cnt_d = 3'(DRAIN_CYCLES);
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (clk_en) begin
          drain_cnt_d = drain_cnt_q - 3'd1;
          if (drain_cnt_q == 3'd1) state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        act_g2f_d  = shd_g2f_q;
        act_f2g_d  = shd_f2g_q;
        act_srst_d = shd_srst_q;
        // x & (x-1) is nonzero exactly when more than one bit is set
        cfg_err_d  = |(shd_f2g_q & (shd_f2g_q - NUM_CHAN'(1)));
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    cfg_busy_d = (state_d != ST_RUN);
  end

  always_comb begin
    srst_cnt_d = srst_cnt_q;
    if (cgra_soft_reset) begin
      srst_cnt_d = 4'(SRST_CYCLES);
    end else if (srst_cnt_q != 4'd0) begin
      srst_cnt_d = srst_cnt_q - 4'd1;
    end
    srst_s_d = cgra_soft_reset | (srst_cnt_q > 4'd1);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      g2f_s0_data[i]  = '0;
      g2f_s0_valid[i] = 1'b0;
      if (state_q != ST_DRAIN && act_g2f_q[i]) begin
        g2f_s0_data[i]  = g2f_dma_data;
        g2f_s0_valid[i] = g2f_dma_valid;
      end
      if (act_srst_q[i]) g2f_s0_valid[i] = srst_s_q;
    end
  end

  always_comb begin
    g2f_pipe_data_d  = g2f_pipe_data_q;
    g2f_pipe_valid_d = g2f_pipe_valid_q;
    if (clk_en) begin
      g2f_pipe_data_d[0]  = g2f_s0_data;
      g2f_pipe_valid_d[0] = g2f_s0_valid;
      for (int unsigned s = 1; s < G2F_PIPE; s++) begin
        g2f_pipe_data_d[s]  = g2f_pipe_data_q[s-1];
        g2f_pipe_valid_d[s] = g2f_pipe_valid_q[s-1];
      end
    end
  end

  always_comb begin
    f2g_s0_data  = '0;
    f2g_s0_valid = 1'b0;
    f2g_found    = 1'b0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      if (!f2g_found && act_f2g_q[i]) begin
        f2g_s0_data  = f2g_data[i];
        f2g_s0_valid = f2g_valid[i];
        f2g_found    = 1'b1;
      end
    end
    if (state_q == ST_DRAIN) f2g_s0_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      act_g2f_q   <= '0;
      act_f2g_q   <= '0;
      act_srst_q  <= '0;
      shd_g2f_q   <= '0;
      shd_f2g_q   <= '0;
      shd_srst_q  <= '0;
      cfg_err_q   <= 1'b0;
      cfg_busy_q  <= 1'b0;
      srst_cnt_q  <= '0;
      srst_s_q    <= 1'b0;
      for (int unsigned s = 0; s < G2F_PIPE; s++) begin
        g2f_pipe_valid_q[s] <= '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) g2f_pipe_data_q[s][i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      drain_cnt_q      <= drain_cnt_d;
      act_g2f_q        <= act_g2f_d;
      act_f2g_q        <= act_f2g_d;
      act_srst_q       <= act_srst_d;
      shd_g2f_q        <= shd_g2f_d;
      shd_f2g_q        <= shd_f2g_d;
      shd_srst_q       <= shd_srst_d;
      cfg_err_q        <= cfg_err_d;
      cfg_busy_q       <= cfg_busy_d;
      srst_cnt_q       <= srst_cnt_d;
      srst_s_q         <= srst_s_d;
      g2f_pipe_data_q  <= g2f_pipe_data_d;
      g2f_pipe_valid_q <= g2f_pipe_valid_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHAN; i++) g2f_data[i] = g2f_pipe_data_q[G2F_PIPE-1][i];
    g2f_valid = g2f_pipe_valid_q[G2F_PIPE-1];
    cfg_busy  = cfg_busy_q;
    cfg_err   = cfg_err_q;
  end

  if (F2G_PIPE == 0) begin : g_f2g_comb
    assign f2g_dma_data  = f2g_s0_data;
    assign f2g_dma_valid = f2g_s0_valid;
  end else begin : g_f2g_pipe
    logic [DATA_WIDTH-1:0] f2g_pipe_data_q [F2G_PIPE];
    logic [DATA_WIDTH-1:0] f2g_pipe_data_d [F2G_PIPE];
    logic [F2G_PIPE-1:0]   f2g_pipe_valid_q, f2g_pipe_valid_d;

    always_comb begin
      f2g_pipe_data_d  = f2g_pipe_data_q;
      f2g_pipe_valid_d = f2g_pipe_valid_q;
      if (clk_en) begin
        f2g_pipe_data_d[0]  = f2g_s0_data;
        f2g_pipe_valid_d[0] = f2g_s0_valid;
        for (int unsigned s = 1; s < F2G_PIPE; s++) begin
          f2g_pipe_data_d[s]  = f2g_pipe_data_q[s-1];
          f2g_pipe_valid_d[s] = f2g_pipe_valid_q[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        f2g_pipe_valid_q <= '0;
        for (int unsigned s = 0; s < F2G_PIPE; s++) f2g_pipe_data_q[s] <= '0;
      end else begin
        f2g_pipe_data_q  <= f2g_pipe_data_d;
        f2g_pipe_valid_q <= f2g_pipe_valid_d;
      end
    end

    assign f2g_dma_data  = f2g_pipe_data_q[F2G_PIPE-1];
    assign f2g_dma_valid = f2g_pipe_valid_q[F2G_PIPE-1];
  end

endmodule
